// File: rtl/seg7_scan_driver_if.sv
// Bus between user logic and the scanning seven-segment driver.
// The driver uses the slave modport; the user side uses the master modport.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 8
);
  logic [4*DIGITS-1:0] DATA;
  logic [DIGITS-1:0]   DP_IN;
  logic [DIGITS-1:0]   BLANK;
  logic                LOAD;
  logic [7:0]          SEG;
  logic [DIGITS-1:0]   AN;
  logic [2:0]          SCAN_IDX;

  modport master (
    output DATA, DP_IN, BLANK, LOAD,
    input  SEG, AN, SCAN_IDX
  );

  modport slave (
    input  DATA, DP_IN, BLANK, LOAD,
    output SEG, AN, SCAN_IDX
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with shadow registers, anode guard
// interval, per-digit blanking and dp. SEG7_LZ_SUPPRESS_EN enables leading-zero suppression.
module seg7_scan_driver #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned GUARD    = 4
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  seg7_scan_driver_if.slave  bus
);
  localparam int unsigned       DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]  GUARD_C  = DIV_W'(GUARD);
  localparam logic [2:0]        IDX_LAST = 3'(DIGITS - 1);

  logic [4*DIGITS-1:0] sh_data_q;
  logic [DIGITS-1:0]   sh_dp_q;
  logic [DIGITS-1:0]   sh_blank_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [2:0]          scan_idx_q;
  logic [DIGITS-1:0]   sup_mask;
  logic [3:0]          nib;
  logic                dp_sel;
  logic                blk_sel;
  logic                guard_on;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'h40;  4'h1: f = 7'h79;  4'h2: f = 7'h24;  4'h3: f = 7'h30;
      4'h4: f = 7'h19;  4'h5: f = 7'h12;  4'h6: f = 7'h02;  4'h7: f = 7'h78;
      4'h8: f = 7'h00;  4'h9: f = 7'h18;  4'hA: f = 7'h08;  4'hB: f = 7'h03;
      4'hC: f = 7'h46;  4'hD: f = 7'h21;  4'hE: f = 7'h06;  default: f = 7'h0E;
    endcase
    return f;
  endfunction

`ifdef SEG7_LZ_SUPPRESS_EN
  logic zrun;
  // Walk from the most significant digit down; digit 0 is never suppressed.
  always_comb begin
    zrun     = 1'b1;
    sup_mask = '0;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      zrun = zrun & (sh_data_q[4*(DIGITS-1-k) +: 4] == 4'h0);
      sup_mask[DIGITS-1-k] = zrun;
    end
  end
`else
  assign sup_mask = '0;
`endif

  assign guard_on = (div_q < GUARD_C);

  always_comb begin
    nib     = '0;
    dp_sel  = 1'b0;
    blk_sel = 1'b0;
    an_d    = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        nib     = sh_data_q[4*i +: 4];
        dp_sel  = sh_dp_q[i];
        blk_sel = sh_blank_q[i] | sup_mask[i];
        an_d[i] = guard_on;
      end
    end
    seg_d = {~dp_sel, blk_sel ? 7'h7F : hex_font(nib)};
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
    end else if (bus.LOAD) begin
      sh_data_q  <= bus.DATA;
      sh_dp_q    <= bus.DP_IN;
      sh_blank_q <= bus.BLANK;
    end
  end

  // Outputs sample pre-edge scan state and shadow, so they trail the counters by one cycle.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_q      <= '0;
      idx_q      <= '0;
      seg_q      <= '1;
      an_q       <= '1;
      scan_idx_q <= '0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      scan_idx_q <= idx_q;
    end
  end

  assign bus.SEG      = seg_q;
  assign bus.AN       = an_q;
  assign bus.SCAN_IDX = scan_idx_q;
endmodule
